// File: rtl/deinterleaver_fsm_pkg.sv
// Shared constants and FSM state types for the QPP block de-interleaver.
package deint_pkg;
  localparam int K_SMALL  = 1056;
  localparam int K_LARGE  = 6144;
  localparam int AW       = 13;
  localparam int F1_SMALL = 17;
  localparam int F2_SMALL = 66;
  localparam int F1_LARGE = 263;
  localparam int F2_LARGE = 480;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_FILL} w_state_e;
  typedef enum logic       {R_IDLE, R_DRAIN}        r_state_e;
endpackage

// File: rtl/deinterleaver_fsm_if.sv
// Block-level handshake bundle: write side (start/in_*) and read side (out_*).
interface deinterleaver_fsm_if;
  logic start;
  logic block_size;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_ready;
  logic out_sop;
  logic out_eop;
  logic busy;
  logic done;

  modport master (
    output start, block_size, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_sop, out_eop, busy, done
  );

  modport slave (
    input  start, block_size, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_sop, out_eop, busy, done
  );
endinterface

// File: rtl/deinterleaver_fsm_qpp_addr_gen.sv
// Incremental QPP address generator: pi(i) = (f1*i + f2*i^2) mod K, one step per accepted bit.
module qpp_addr_gen #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          step,
  input  logic [AW:0]   K,
  input  logic [AW:0]   f1,
  input  logic [AW:0]   f2,
  output logic [AW-1:0] pi
);
  logic [AW:0] pi_q, pi_d;
  logic [AW:0] g_q, g_d;

  // Both operands are already reduced below K, so one subtract restores the range.
  function automatic logic [AW:0] mod_k(input logic [AW:0] s, input logic [AW:0] m);
    return (s >= m) ? (s - m) : s;
  endfunction

  always_comb begin
    pi_d = pi_q;
    g_d  = g_q;
    if (init) begin
      pi_d = '0;
      g_d  = mod_k(f1 + f2, K);
    end else if (step) begin
      pi_d = mod_k(pi_q + g_q, K);
      g_d  = mod_k(g_q + {f2[AW-1:0], 1'b0}, K);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pi_q <= '0;
      g_q  <= '0;
    end else begin
      pi_q <= pi_d;
      g_q  <= g_d;
    end
  end

  assign pi = pi_q[AW-1:0];
endmodule

// File: rtl/deinterleaver_fsm.sv
// Ping-pong QPP de-interleaver: writer scatters bits to pi(i) in one bank while the reader
// drains the other bank in natural order.
module deinterleaver_fsm #(
  parameter int K_SMALL = deint_pkg::K_SMALL,
  parameter int K_LARGE = deint_pkg::K_LARGE,
  parameter int AW      = deint_pkg::AW
) (
  input  logic               clk,
  input  logic               reset,
  deinterleaver_fsm_if.slave bus
);
  import deint_pkg::*;

  localparam int KW = AW + 1;
  localparam logic [KW-1:0] KS  = KW'(K_SMALL);
  localparam logic [KW-1:0] KL  = KW'(K_LARGE);
  localparam logic [KW-1:0] ONE = KW'(1);

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic          sel_q, sel_d, cur_sel;
  logic [KW-1:0] i_q, i_d, j_q, j_d;
  logic          wb_q, wb_d, rb_q, rb_d;
  logic [1:0]    full_q, full_d;
  logic [KW-1:0] bk0_q, bk0_d, bk1_q, bk1_d;
  logic          in_ready_q, in_ready_d, busy_q, busy_d;
  logic          out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic          done_q, done_d;
  logic          qpp_init, qpp_step, wr_en, set_full, clr_full;
  logic [KW-1:0] cur_k, cur_f1, cur_f2, rk;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [0:0]    mem0 [0:K_LARGE-1];
  logic [0:0]    mem1 [0:K_LARGE-1];
  logic [0:0]    rd0_q, rd1_q;

  // Block size is taken live from the port only at the moment start is sampled.
  assign cur_sel = (w_state_q == W_IDLE) ? bus.block_size : sel_q;
  assign cur_k   = cur_sel ? KL : KS;
  assign cur_f1  = cur_sel ? KW'(F1_LARGE) : KW'(F1_SMALL);
  assign cur_f2  = cur_sel ? KW'(F2_LARGE) : KW'(F2_SMALL);

  qpp_addr_gen #(.AW(AW)) u_qpp (
    .clk   (clk),
    .reset (reset),
    .init  (qpp_init),
    .step  (qpp_step),
    .K     (cur_k),
    .f1    (cur_f1),
    .f2    (cur_f2),
    .pi    (wr_addr)
  );

  always_comb begin
    w_state_d = w_state_q;
    sel_d     = sel_q;
    i_d       = i_q;
    wb_d      = wb_q;
    bk0_d     = bk0_q;
    bk1_d     = bk1_q;
    qpp_init  = 1'b0;
    qpp_step  = 1'b0;
    wr_en     = 1'b0;
    set_full  = 1'b0;
    case (w_state_q)
      W_IDLE: if (bus.start) begin
        sel_d     = bus.block_size;
        i_d       = '0;
        qpp_init  = 1'b1;
        w_state_d = W_WAIT;
      end
      W_WAIT: if (!full_q[wb_q]) w_state_d = W_FILL;
      W_FILL: if (bus.in_valid && in_ready_q) begin
        wr_en    = 1'b1;
        qpp_step = 1'b1;
        if (i_q == cur_k - ONE) begin
          set_full  = 1'b1;
          if (wb_q) bk1_d = cur_k;
          else      bk0_d = cur_k;
          wb_d      = ~wb_q;
          w_state_d = W_IDLE;
        end else begin
          i_d = i_q + ONE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    in_ready_d = (w_state_d == W_FILL);
    busy_d     = (w_state_d != W_IDLE);
  end

  // Reader: the output register always holds bank[rb][j]; on a handshake it is refilled
  // from j+1 in the same edge, giving one bit per cycle under continuous out_ready.
  assign rk = rb_q ? bk1_q : bk0_q;

  always_comb begin
    r_state_d   = r_state_q;
    j_d         = j_q;
    rb_d        = rb_q;
    clr_full    = 1'b0;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    done_d      = 1'b0;
    rd_addr     = j_q[AW-1:0];
    case (r_state_q)
      R_IDLE: if (full_q[rb_q]) begin
        j_d       = '0;
        r_state_d = R_DRAIN;
      end
      R_DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_sop_d   = (j_q == '0);
          out_eop_d   = (j_q == rk - ONE);
        end else if (bus.out_ready) begin
          if (j_q == rk - ONE) begin
            clr_full    = 1'b1;
            rb_d        = ~rb_q;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            r_state_d   = R_IDLE;
          end else begin
            j_d       = j_q + ONE;
            rd_addr   = j_d[AW-1:0];
            out_sop_d = 1'b0;
            out_eop_d = (j_d == rk - ONE);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Writer and reader never touch the same bank's flag in one cycle.
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d[rb_q] = 1'b0;
    if (set_full) full_d[wb_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      sel_q       <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= '0;
      bk0_q       <= '0;
      bk1_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      sel_q       <= sel_d;
      i_q         <= i_d;
      j_q         <= j_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      bk0_q       <= bk0_d;
      bk1_q       <= bk1_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wb_q) mem0[wr_addr] <= bus.in_bit;
    if (wr_en &&  wb_q) mem1[wr_addr] <= bus.in_bit;
    rd0_q <= mem0[rd_addr];
    rd1_q <= mem1[rd_addr];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.done      = done_q;
  assign bus.out_bit   = out_valid_q & (rb_q ? rd1_q[0] : rd0_q[0]);
endmodule

// File: tb/tb_deinterleaver_fsm.sv
// Scoreboard bench for deinterleaver_fsm: stimulus pushes natural-order expectations,
// a negedge monitor pops and compares every accepted output bit.
module tb_deinterleaver_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  deinterleaver_fsm_if bus();

  deinterleaver_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {logic b; logic sop; logic eop;} exp_t;
  exp_t sb[$];

  int   checks = 0;
  int   errors = 0;
  logic blk [6144];
  logic nat [6144];
  int   done_cnt = 0;
  int   ones_cnt = 0, ones_pos = -1, eop_pos = -1, jpos = 0;
  int   gap_low = 0;
  logic exp_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [3:0] prev_vec = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: handshakes, stall stability and done timing.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop}, prev_vec);
      if (exp_done || bus.done) chk("done_pulse", bus.done, exp_done);
      if (bus.done) done_cnt++;
      exp_done = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = sb.pop_front();
          chk("out_bit", bus.out_bit, e.b);
          chk("out_sop", bus.out_sop, e.sop);
          chk("out_eop", bus.out_eop, e.eop);
        end
        if (bus.out_sop) begin
          jpos = 0;
          ones_cnt = 0;
        end
        if (bus.out_bit) begin
          ones_cnt++;
          ones_pos = jpos;
        end
        if (bus.out_eop) begin
          eop_pos = jpos;
          exp_done = 1'b1;
        end
        jpos++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_vec   = {bus.out_valid, bus.out_bit, bus.out_sop, bus.out_eop};
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_bit"},   bus.out_bit,   0);
    chk({tag, "_out_sop"},   bus.out_sop,   0);
    chk({tag, "_out_eop"},   bus.out_eop,   0);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_done"},      bus.done,      0);
  endtask

  task automatic fill_pattern(input int k, input int seed);
    for (int i = 0; i < 6144; i++) blk[i] = (i < k) ? (((i * 13 + seed) % 7) < 3) : 1'b0;
  endtask

  task automatic start_blk(input logic size);
    @(posedge clk); #1;
    gap_low = bus.in_ready ? 0 : 1;
    bus.start      = 1'b1;
    bus.block_size = size;
  endtask

  task automatic feed_blk(input int k, input int glitch_at, input int abort_at, input bit chk_pi);
    int f1, f2;
    int pitab [3];
    longint p, ii;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    pitab = '{0, 743, 2446};
    if (abort_at < 0) begin
      for (int i = 0; i < k; i++) begin
        ii = i;
        p = (f1 * ii + f2 * ii * ii) % k;
        nat[p] = blk[i];
      end
      for (int j = 0; j < k; j++) sb.push_back('{b: nat[j], sop: (j == 0), eop: (j == k - 1)});
    end
    for (int i = 0; i < k; i++) begin
      int guard;
      guard = 0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (!bus.in_ready && guard < 20000) begin
        gap_low++;
        guard++;
        @(posedge clk); #1;
      end
      if (guard >= 20000) begin
        fail_now("in_ready_timeout");
        bus.in_valid = 1'b0;
        return;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk_outputs_zero("abort");
        return;
      end
      if (i == glitch_at) begin
        bus.start      = 1'b1;
        bus.block_size = ~bus.block_size;
      end
      if (chk_pi && i < 3) chk("qpp_pi", int'(dut.u_qpp.pi), pitab[i]);
      bus.in_valid = 1'b1;
      bus.in_bit   = blk[i];
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && g < 30000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 30000) fail_now("drain_timeout");
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, viol, g;
    logic sz;
    bus.start = 1'b0; bus.block_size = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Single 1 at i=1 of K=1056 lands at j=83.
    fill_pattern(1056, 0);
    for (int i = 0; i < 6144; i++) blk[i] = 1'b0;
    blk[1] = 1'b1;
    d0 = done_cnt;
    start_blk(1'b0);
    feed_blk(1056, -1, -1, 1'b0);
    wait_drain();
    chk("t1_ones", ones_cnt, 1);
    chk("t1_pos", ones_pos, 83);
    chk("t1_eop_pos", eop_pos, 1055);
    chk("t1_done", done_cnt - d0, 1);

    // Single 1 at i=2 of K=6144 lands at j=2446; pi starts 0, 743, 2446.
    for (int i = 0; i < 6144; i++) blk[i] = 1'b0;
    blk[2] = 1'b1;
    start_blk(1'b1);
    feed_blk(6144, -1, -1, 1'b1);
    wait_drain();
    chk("t2_ones", ones_cnt, 1);
    chk("t2_pos", ones_pos, 2446);
    chk("t2_eop_pos", eop_pos, 6143);

    // Back-to-back 1056 / 6144 / 1056 with the 2-cycle start gap.
    for (int b = 0; b < 3; b++) begin
      sz = (b == 1);
      fill_pattern(sz ? 6144 : 1056, b + 1);
      start_blk(sz);
      feed_blk(sz ? 6144 : 1056, -1, -1, 1'b0);
      if (b > 0) chk("t3_gap", gap_low, 2);
    end
    wait_drain();

    // Long out_ready stall mid-drain; third block waits for the first bank.
    fork
      begin
        int gc;
        gc = 0;
        while (!bus.out_valid && gc < 5000) begin
          @(posedge clk); #1;
          gc++;
        end
        repeat (100) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3000) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      begin
        fill_pattern(1056, 11);
        start_blk(1'b0);
        feed_blk(1056, -1, -1, 1'b0);
        fill_pattern(1056, 12);
        start_blk(1'b0);
        feed_blk(1056, -1, -1, 1'b0);
        start_blk(1'b0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
      end
    join
    chk("t4_busy", bus.busy, 1);
    chk("t4_wait_ready", bus.in_ready, 0);
    viol = 0;
    g = 0;
    while (!bus.done && g < 8000) begin
      if (bus.in_ready) viol++;
      @(posedge clk); #1;
      g++;
    end
    if (bus.in_ready) viol++;
    chk("t4_hold_until_done", viol, 0);
    if (g >= 8000) fail_now("t4_done_timeout");
    @(posedge clk); #1;
    chk("t4_resume_ready", bus.in_ready, 1);
    fill_pattern(1056, 13);
    feed_blk(1056, -1, -1, 1'b0);
    wait_drain();

    // in_valid outside W_FILL and start during W_FILL are both ignored.
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    fill_pattern(1056, 21);
    start_blk(1'b0);
    feed_blk(1056, 300, -1, 1'b0);
    wait_drain();

    // Reset at i=500, then a fresh block.
    fill_pattern(1056, 31);
    start_blk(1'b0);
    feed_blk(1056, -1, 500, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t6_sb_empty", sb.size(), 0);
    fill_pattern(1056, 32);
    start_blk(1'b0);
    feed_blk(1056, -1, -1, 1'b0);
    wait_drain();

    chk("blocks_done", done_cnt, 10);
    chk("sb_final_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/deinterleaver_fsm.md
# deinterleaver_fsm

Receive-side counterpart of the turbo-encoder interleaver controller: accepts a QPP-interleaved bit stream for one LTE code block (K = 1056 or K = 6144) and returns it in natural order. Inside are two ping-pong bit banks, a write-side FSM that scatters input bits to addresses π(i), and a read-side FSM that drains a full bank sequentially. One bank fills while the other drains. It sits between the channel/decoder input stage and the downstream consumer of natural-order bits.

## Interface
Parameters:
- `K_SMALL`, default 1056, small block length; QPP f1 = 17, f2 = 66.
- `K_LARGE`, default 6144, large block length; QPP f1 = 263, f2 = 480.
- `AW`, default 13, address width (must hold K_LARGE − 1).

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset`, in, 1, asynchronous, active-high; clears all state.
- `start`, in, 1, one-cycle pulse announcing a new block; sampled only in W_IDLE.
- `block_size`, in, 1, sampled with `start`: 0 selects K_SMALL, 1 selects K_LARGE.
- `in_valid`, in, 1, input bit valid.
- `in_bit`, in, 1, interleaved bit c′(i).
- `in_ready`, out, 1, high in W_FILL only.
- `out_valid`, out, 1, output bit valid.
- `out_bit`, out, 1, natural-order bit c(j).
- `out_ready`, in, 1, downstream accept.
- `out_sop` / `out_eop`, out, 1, qualify j = 0 / j = K−1 with `out_valid`.
- `busy`, out, 1, writer not in W_IDLE.
- `done`, out, 1, one-cycle pulse after the last output bit of a block is accepted.

## Operation
- QPP: π(i) = (f1·i + f2·i²) mod K. Computed incrementally: π(0) = 0, g(0) = (f1+f2) mod K; π(i+1) = π(i)+g(i) mod K; g(i+1) = g(i)+2f2 mod K.
  - Each sum is < 2K, so one conditional subtract is enough.
  - All arithmetic is AW+1 bits wide.
- Write FSM:
  - W_IDLE: on `start`, latch K, clear i/π/g, go to W_WAIT.
  - W_WAIT: advance to W_FILL once the write bank is empty.
  - W_FILL: on each `in_valid && in_ready`, write `in_bit` to bank[wb][π(i)], then i++.
  - At i = K−1 accepted: mark bank wb full, store its K, toggle wb, return to W_IDLE.
- Read FSM:
  - R_IDLE: when bank rb is full, go to R_DRAIN with j = 0.
  - R_DRAIN: present bank[rb][j]; j advances on `out_valid && out_ready`.
  - After j = K−1 is accepted: clear full[rb], toggle rb, pulse `done`, return to R_IDLE.
- `start` while `busy` is ignored. `in_valid` outside W_FILL is ignored. `in_bit` is don't-care when not valid.
- `out_valid`/`out_bit`/`out_sop`/`out_eop` hold stable while `out_ready` is low.
- Simultaneous events:
  - A bank freeing in the same cycle the writer waits on it: W_WAIT → W_FILL on the next edge.
  - Writer completing a bank while the reader is in R_IDLE: the reader starts on the following edge.
- Reset mid-block: both FSMs go to idle, full flags clear, wb = rb = 0. A partial block is discarded; bank contents are don't-care.
- Reset values: `in_ready`, `out_valid`, `out_bit`, `out_sop`, `out_eop`, `busy`, `done` are all 0.

## Timing
- `start` at edge N → `busy` = 1 after N. `in_ready` = 1 after N+1 if the bank is empty.
- Throughput: 1 bit/cycle in and out. Sustained blocks with no gaps apart from the 2-cycle start overhead.
- Last input accepted at edge M → full set at M → `out_valid` high after M+2 (1 cycle to enter R_DRAIN, 1 cycle registered bank read).
- Output path is registered, with a one-entry prefetch so that back-to-back `out_ready` gives 1 bit/cycle.
- `done` is high for exactly the cycle after the `out_eop` handshake.
- `in_ready` drops combinationally-free: it is registered and low in the cycle after the K-th accept.

## Structure
- `deint_pkg`: K_SMALL/K_LARGE, f1/f2 per size, AW, write-state and read-state enums.
- Sub-module `qpp_addr_gen`: ports clk, reset, init, step, K, f1, f2 → π. Holds π/g registers and the mod-K adders.
- Banks: two `reg [0:0] mem [0:K_LARGE-1]` arrays, inferred as simple dual-port RAM (1 write port, 1 registered read port).

## Test plan
- K = 1056, input bit 1 only at i = 1 (rest 0) → single `out_bit` = 1 at j = 83; `out_eop` at j = 1055; one `done` pulse.
- K = 6144, `in_bit` = 1 at i = 2 only → `out_bit` = 1 at j = 2446 only. Also the `qpp_addr_gen` π sequence starts 0, 743, 2446.
- Back-to-back blocks 1056 then 6144 then 1056 with constant `out_ready` = 1:
  - each output equals the reference model's de-interleaved block;
  - `in_ready` is never low for more than 2 cycles between blocks.
- `out_ready` held low for 3000 cycles mid-drain:
  - the second block fills the other bank;
  - a third `start` leaves the writer in W_WAIT with `in_ready` = 0 until the first bank's `done`;
  - no data is lost.
- `start` pulsed in W_FILL → ignored, the block completes normally. `in_valid` with `in_ready` = 0 → no write occurs.
- Reset asserted at i = 500 of a K = 1056 block → all outputs 0 immediately. A fresh K = 1056 block afterwards de-interleaves correctly.
